// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
//
// Purpose:
//    SPI target that stands in for a Winbond-style serial flash so the flash
//    paging logic and boot code can run against an image held in a local
//    BRAM/ROM. It answers three commands:
//       0x03  Read Data        - 24-bit address, then image bytes forever
//       0x05  Read Status-1    - STATUS_VALUE repeated
//       0x9F  JEDEC ID         - three ID bytes, then 0xFF forever
//    Any other opcode is ignored until chip select is released.
//
// Ports:
//    clk          system clock
//    reset        synchronous, active-high reset
//    spi_cs       chip select from the initiator, active low
//    spi_clk      SPI clock from the initiator, idle low (mode 0)
//    spi_mosi     serial data from the initiator
//    spi_miso     serial data to the initiator
//    mem_address  byte address into the image memory
//    mem_data     image byte, valid one clk after mem_address changes
//    active       high while a selected transaction is being handled
// -----------------------------------------------------------------------------
module spi_flash_responder #(
   parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
   parameter logic [7:0]  STATUS_VALUE = 8'h00,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_cs,
   input  logic        spi_clk,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic [23:0] mem_address,
   input  logic [7:0]  mem_data,
   output logic        active
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_FETCH,
      ST_DATA,
      ST_IGNORE
   } state_t;

   typedef enum logic [1:0] {
      CMD_READ,
      CMD_STATUS,
      CMD_JEDEC
   } cmd_t;

   // Synchronizer chains for the three asynchronous SPI inputs.
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   // Previous synchronized levels, used for edge detection.
   logic cs_prev_q,   cs_prev_d;
   logic sclk_prev_q, sclk_prev_d;

   // Transaction state.
   state_t      state_q,      state_d;
   cmd_t        cmd_q,        cmd_d;
   logic [4:0]  bit_cnt_q,    bit_cnt_d;
   logic [23:0] rx_q,         rx_d;
   logic [7:0]  tx_q,         tx_d;
   logic [1:0]  byte_idx_q,   byte_idx_d;
   logic        fetch_wait_q, fetch_wait_d;
   logic [23:0] mem_addr_q,   mem_addr_d;
   logic        miso_q,       miso_d;
   logic        active_q,     active_d;

   logic       cs_s;
   logic       sclk_s;
   logic       mosi_s;
   logic       cs_rise;
   logic       cs_fall;
   logic       sclk_rise;
   logic       sclk_fall;
   logic [7:0] next_byte;

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // The cs history resets low, so after a reset a falling edge can only be
   // seen once chip select has first been observed high. This is what makes
   // the target ignore a transaction that was already under way at reset.
   assign cs_rise   = ~cs_prev_q &  cs_s;
   assign cs_fall   =  cs_prev_q & ~cs_s;
   assign sclk_rise = ~sclk_prev_q &  sclk_s;
   assign sclk_fall =  sclk_prev_q & ~sclk_s;

   assign spi_miso    = miso_q;
   assign mem_address = mem_addr_q;
   assign active      = active_q;

   // Shift each raw SPI input one stage further down its synchronizer chain
   // and remember the last synchronized level for edge detection.
   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_d   = cs_s;
      sclk_prev_d = sclk_s;
   end

   // Next-state and output logic for the command/address/data sequencer.
   // A chip-select release wins over everything else, including an SPI
   // clock edge seen in the same cycle.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      byte_idx_d   = byte_idx_q;
      fetch_wait_d = fetch_wait_q;
      mem_addr_d   = mem_addr_q;
      miso_d       = miso_q;
      active_d     = active_q;
      next_byte    = 8'h00;

      if (cs_rise) begin
         state_d   = ST_IDLE;
         miso_d    = 1'b0;
         active_d  = 1'b0;
         bit_cnt_d = 5'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  bit_cnt_d = 5'd0;
                  active_d  = 1'b1;
                  state_d   = ST_CMD;
               end
            end

            ST_CMD: begin
               if (sclk_rise) begin
                  rx_d      = {rx_q[22:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     unique case (rx_d[7:0])
                        8'h03: begin
                           cmd_d   = CMD_READ;
                           state_d = ST_ADDR;
                        end
                        8'h05: begin
                           cmd_d   = CMD_STATUS;
                           tx_d    = STATUS_VALUE;
                           state_d = ST_DATA;
                        end
                        8'h9F: begin
                           cmd_d      = CMD_JEDEC;
                           tx_d       = JEDEC_ID[23:16];
                           byte_idx_d = 2'd1;
                           state_d    = ST_DATA;
                        end
                        default: begin
                           state_d = ST_IGNORE;
                        end
                     endcase
                  end
               end
            end

            ST_ADDR: begin
               if (sclk_rise) begin
                  rx_d      = {rx_q[22:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d    = 5'd0;
                     mem_addr_d   = rx_d;
                     fetch_wait_d = 1'b0;
                     state_d      = ST_FETCH;
                  end
               end
            end

            // The memory answers one clk after the address moves, so wait a
            // cycle, capture the first byte, then move the address on by one
            // so the following byte is already waiting on mem_data.
            ST_FETCH: begin
               if (!fetch_wait_q) begin
                  fetch_wait_d = 1'b1;
               end else begin
                  tx_d       = mem_data;
                  mem_addr_d = mem_addr_q + 24'd1;
                  state_d    = ST_DATA;
               end
            end

            // bit_cnt counts bits already driven in the current byte; the
            // falling edge after the eighth bit swaps in the next byte and
            // drives its MSB straight away.
            ST_DATA: begin
               if (sclk_fall) begin
                  if (bit_cnt_q == 5'd8) begin
                     unique case (cmd_q)
                        CMD_READ: begin
                           next_byte  = mem_data;
                           mem_addr_d = mem_addr_q + 24'd1;
                        end
                        CMD_STATUS: begin
                           next_byte = STATUS_VALUE;
                        end
                        default: begin
                           unique case (byte_idx_q)
                              2'd1:    next_byte = JEDEC_ID[15:8];
                              2'd2:    next_byte = JEDEC_ID[7:0];
                              default: next_byte = 8'hFF;
                           endcase
                           if (byte_idx_q != 2'd3) begin
                              byte_idx_d = byte_idx_q + 2'd1;
                           end
                        end
                     endcase
                     miso_d    = next_byte[7];
                     tx_d      = {next_byte[6:0], 1'b0};
                     bit_cnt_d = 5'd1;
                  end else begin
                     miso_d    = tx_q[7];
                     tx_d      = {tx_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end

            ST_IGNORE: begin
               miso_d = 1'b0;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State register for synchronizers, edge history and the sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_sync_q    <= '0;
         sclk_sync_q  <= '0;
         mosi_sync_q  <= '0;
         cs_prev_q    <= 1'b0;
         sclk_prev_q  <= 1'b0;
         state_q      <= ST_IDLE;
         cmd_q        <= CMD_READ;
         bit_cnt_q    <= 5'd0;
         rx_q         <= 24'd0;
         tx_q         <= 8'd0;
         byte_idx_q   <= 2'd0;
         fetch_wait_q <= 1'b0;
         mem_addr_q   <= 24'd0;
         miso_q       <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         cs_sync_q    <= cs_sync_d;
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         cs_prev_q    <= cs_prev_d;
         sclk_prev_q  <= sclk_prev_d;
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         byte_idx_q   <= byte_idx_d;
         fetch_wait_q <= fetch_wait_d;
         mem_addr_q   <= mem_addr_d;
         miso_q       <= miso_d;
         active_q     <= active_d;
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_responder
//
// Purpose:
//    Self-checking bench for spi_flash_responder. Acts as the SPI initiator
//    (mode 0) and as the image memory. Expected read bytes are queued before
//    each transaction and popped as each byte arrives on spi_miso.
//
// Ports:
//    none (top-level bench)
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

   localparam int HALF        = 6;
   localparam int SYNC_STAGES = 2;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        spi_cs   = 1'b1;
   logic        spi_clk  = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [23:0] mem_address;
   logic [7:0]  mem_data = 8'h00;
   logic        active;

   int compared_count = 0;
   int mismatch_count = 0;

   logic [7:0] expected_q[$];

   // Watches mem_address for the first value it moves to once armed.
   logic        addr_armed = 1'b0;
   logic        addr_seen  = 1'b0;
   logic [23:0] first_addr = 24'd0;
   logic [23:0] last_addr  = 24'd0;

   spi_flash_responder #(
      .JEDEC_ID     (24'hEF4018),
      .STATUS_VALUE (8'h00),
      .SYNC_STAGES  (SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_cs      (spi_cs),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .active      (active)
   );

   // System clock, 10 ns period.
   always #5 clk = ~clk;

   // Image contents: byte i holds i[7:0], except the four wrap-test bytes.
   function automatic logic [7:0] image(input logic [23:0] a);
      case (a)
         24'hFFFFFE: return 8'hAA;
         24'hFFFFFF: return 8'hBB;
         24'h000000: return 8'hCC;
         24'h000001: return 8'hDD;
         default:    return a[7:0];
      endcase
   endfunction

   // Synchronous-read image memory: data follows the address by one clk.
   always @(posedge clk) begin
      mem_data <= image(mem_address);
   end

   // Record the first address change after arming.
   always @(negedge clk) begin
      if (addr_armed && !addr_seen && (mem_address !== last_addr)) begin
         first_addr = mem_address;
         addr_seen  = 1'b1;
      end
      last_addr = mem_address;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One mode-0 bit: drive mosi while spi_clk is low, sample miso on the rise.
   task automatic xferBit(input logic b, output logic r);
      @(negedge clk);
      spi_mosi = b;
      waitClocks(HALF);
      spi_clk = 1'b1;
      r = spi_miso;
      waitClocks(HALF);
      spi_clk = 1'b0;
   endtask

   task automatic xferByte(input logic [7:0] tx, output logic [7:0] rx);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         xferBit(tx[i], b);
         rx[i] = b;
      end
   endtask

   task automatic csLow();
      @(negedge clk);
      spi_cs = 1'b0;
      waitClocks(2);
   endtask

   task automatic csHigh();
      @(negedge clk);
      spi_cs = 1'b1;
      waitClocks(2 * HALF);
   endtask

   // Run one full transaction: header bytes (MSB-first from 'header'), then
   // n_read dummy bytes whose returned values are checked against the queue.
   task automatic applyStimulus(input string tag, input logic [31:0] header,
                                input int header_len, input int n_read);
      logic [7:0] rx;
      logic [7:0] exp_byte;
      csLow();
      for (int i = 0; i < header_len; i++) begin
         xferByte(header[31-8*i -: 8], rx);
      end
      for (int i = 0; i < n_read; i++) begin
         xferByte(8'h00, rx);
         if (expected_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            exp_byte = expected_q.pop_front();
            checkOutput(tag, {24'd0, rx}, {24'd0, exp_byte});
         end
      end
      csHigh();
   endtask

   initial begin
      logic [7:0] rx;
      logic       b;
      int         n;

      $display("[TB] starting spi_flash_responder bench");

      // Reset with chip select idle.
      reset    = 1'b1;
      spi_cs   = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      waitClocks(3);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_miso",    {31'd0, spi_miso}, 32'd0);
      checkOutput("reset_active",  {31'd0, active},   32'd0);
      checkOutput("reset_address", {8'd0, mem_address}, 32'd0);
      waitClocks(2 * HALF);

      // Plain read starting at 0x001234.
      addr_armed = 1'b1;
      expected_q.push_back(8'h34);
      expected_q.push_back(8'h35);
      expected_q.push_back(8'h36);
      expected_q.push_back(8'h37);
      applyStimulus("read", 32'h03001234, 4, 4);
      checkOutput("read_addr_seen",  {31'd0, addr_seen}, 32'd1);
      checkOutput("read_addr_first", {8'd0, first_addr}, 32'h00001234);

      // Read across the top of the address space.
      expected_q.push_back(8'hAA);
      expected_q.push_back(8'hBB);
      expected_q.push_back(8'hCC);
      expected_q.push_back(8'hDD);
      applyStimulus("wrap", 32'h03FFFFFE, 4, 4);

      // JEDEC ID followed by the 0xFF filler.
      expected_q.push_back(8'hEF);
      expected_q.push_back(8'h40);
      expected_q.push_back(8'h18);
      expected_q.push_back(8'hFF);
      applyStimulus("jedec", 32'h9F000000, 1, 4);

      // Status register repeats.
      expected_q.push_back(8'h00);
      expected_q.push_back(8'h00);
      applyStimulus("status", 32'h05000000, 1, 2);

      // Unknown opcode: miso stays low.
      expected_q.push_back(8'h00);
      applyStimulus("unknown", 32'hAB000000, 1, 1);

      // Abort partway through the second address byte.
      csLow();
      xferByte(8'h03, rx);
      xferByte(8'h00, rx);
      for (int i = 0; i < 3; i++) begin
         xferBit(1'b1, b);
      end
      checkOutput("abort_active_before", {31'd0, active}, 32'd1);
      @(negedge clk);
      spi_cs = 1'b1;
      n = 0;
      while (active && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("abort_active_after", {31'd0, active}, 32'd0);
      checkOutput("abort_drop_latency", {31'd0, (n <= SYNC_STAGES + 1)}, 32'd1);
      waitClocks(2 * HALF);

      // A fresh read after the abort must start cleanly.
      expected_q.push_back(8'h10);
      applyStimulus("abort_read", 32'h03000010, 4, 1);

      checkOutput("sb_drained", expected_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
      $finish;
   end

endmodule
